// File: rtl/pkt_rx_framer.sv
// Receive framer: filters session notifications by length, issues read requests and
// re-frames payload beats by notification length. Stats counters under PKT_RX_STATS_EN.

module pkt_rx_framer_fifo #(
  parameter int unsigned W         = 8,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  logic [W-1:0]       mem [0:(1<<ADDR_BITS)-1];
  logic [ADDR_BITS:0] wr_ptr;
  logic [ADDR_BITS:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_BITS-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (ADDR_BITS+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (ADDR_BITS+1)'(1);
    end
  end

  // Show-ahead read: the head word stays put until popped, which keeps downstream data stable.
  assign rdata = mem[rd_ptr[ADDR_BITS-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                 (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
endmodule

module pkt_rx_framer #(
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned NOTIF_W   = 88,
  parameter int unsigned MIN_LEN   = 64,
  parameter int unsigned MAX_LEN   = 4096,
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NOTIF_W-1:0]          s_axis_notifications_TDATA,
  input  logic                        s_axis_notifications_TVALID,
  output logic                        s_axis_notifications_TREADY,
  input  logic [DATA_W:0]             s_axis_rx_data_TDATA,
  input  logic                        s_axis_rx_data_TVALID,
  output logic                        s_axis_rx_data_TREADY,
  output logic [31:0]                 m_axis_read_package_TDATA,
  output logic                        m_axis_read_package_TVALID,
  input  logic                        m_axis_read_package_TREADY,
  output logic [NOTIF_W+DATA_W:0]     pkt_tx_TDATA,
  output logic                        pkt_tx_TVALID,
  input  logic                        pkt_tx_TREADY,
`ifdef PKT_RX_STATS_EN
  output logic [31:0]                 drop_count,
  output logic [31:0]                 pkt_count,
`endif
  output logic                        err_len_mismatch
);
  localparam int unsigned BEAT_BYTES = DATA_W / 8;

  typedef enum logic {O_IDLE, O_STREAM} state_t;

  state_t              state;
  state_t              state_next;
  logic [15:0]         beat_cnt;
  logic [15:0]         beat_cnt_next;
  logic                run;

  logic                notif_push;
  logic                notif_pop;
  logic                notif_empty;
  logic                notif_full;
  logic [NOTIF_W-1:0]  notif_head;

  logic                pay_push;
  logic                pay_pop;
  logic                pay_empty;
  logic                pay_full;
  logic [DATA_W:0]     pay_head;

  logic                meta_push;
  logic                meta_pop;
  logic                meta_empty;
  logic                meta_full;
  logic [NOTIF_W-1:0]  meta_head;

  logic [31:0]         head_len;
  logic [31:0]         meta_len;
  logic                len_ok;
  logic                drop;
  logic                rd_fire;
  logic                tx_fire;
  logic                gen_tlast;

  // Readies stay low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  pkt_rx_framer_fifo #(.W(NOTIF_W), .ADDR_BITS(ADDR_BITS)) u_notif_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (notif_push),
    .wdata (s_axis_notifications_TDATA),
    .pop   (notif_pop),
    .rdata (notif_head),
    .empty (notif_empty),
    .full  (notif_full)
  );

  pkt_rx_framer_fifo #(.W(DATA_W+1), .ADDR_BITS(ADDR_BITS)) u_pay_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pay_push),
    .wdata (s_axis_rx_data_TDATA),
    .pop   (pay_pop),
    .rdata (pay_head),
    .empty (pay_empty),
    .full  (pay_full)
  );

  pkt_rx_framer_fifo #(.W(NOTIF_W), .ADDR_BITS(ADDR_BITS)) u_meta_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (meta_push),
    .wdata (notif_head),
    .pop   (meta_pop),
    .rdata (meta_head),
    .empty (meta_empty),
    .full  (meta_full)
  );

  assign s_axis_notifications_TREADY = run & ~notif_full;
  assign notif_push                  = s_axis_notifications_TVALID & s_axis_notifications_TREADY;
  assign s_axis_rx_data_TREADY       = run & ~pay_full;
  assign pay_push                    = s_axis_rx_data_TVALID & s_axis_rx_data_TREADY;

  assign head_len = {16'd0, notif_head[31:16]};
  assign len_ok   = (head_len >= MIN_LEN) && (head_len <= MAX_LEN) &&
                    ((head_len % BEAT_BYTES) == 32'd0);

  // Rejected heads leave in one cycle; accepted heads wait for read handshake + metadata room.
  assign drop                       = ~notif_empty & ~len_ok;
  assign m_axis_read_package_TVALID = ~notif_empty & len_ok & ~meta_full;
  assign m_axis_read_package_TDATA  = notif_head[31:0];
  assign rd_fire                    = m_axis_read_package_TVALID & m_axis_read_package_TREADY;
  assign notif_pop                  = drop | rd_fire;
  assign meta_push                  = rd_fire;

  assign meta_len = {16'd0, meta_head[31:16]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= O_IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    pkt_tx_TVALID = 1'b0;
    pay_pop       = 1'b0;
    meta_pop      = 1'b0;
    case (state)
      O_IDLE: begin
        if (!meta_empty) begin
          state_next    = O_STREAM;
          beat_cnt_next = 16'(meta_len / BEAT_BYTES);
        end
      end
      O_STREAM: begin
        pkt_tx_TVALID = ~pay_empty;
        if (!pay_empty && pkt_tx_TREADY) begin
          pay_pop       = 1'b1;
          beat_cnt_next = beat_cnt - 16'd1;
          if (beat_cnt == 16'd1) begin
            meta_pop   = 1'b1;
            state_next = O_IDLE;
          end
        end
      end
      default: state_next = O_IDLE;
    endcase
  end

  // Framing comes from the counter; the incoming tlast only feeds the mismatch flag.
  assign gen_tlast        = (beat_cnt == 16'd1);
  assign tx_fire          = pkt_tx_TVALID & pkt_tx_TREADY;
  assign pkt_tx_TDATA     = {meta_head, gen_tlast, pay_head[DATA_W-1:0]};
  assign err_len_mismatch = tx_fire & (pay_head[DATA_W] != gen_tlast);

`ifdef PKT_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
      pkt_count  <= '0;
    end else begin
      if (drop)     drop_count <= drop_count + 32'd1;
      if (meta_pop) pkt_count  <= pkt_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pkt_rx_framer.md
PKT_RX_FRAMER -- requirements
Module: pkt_rx_framer

Interface
REQ-001 SHALL have parameters: DATA_W, default 512, payload beat width in bits (multiple of 8).
REQ-002 SHALL have parameters: NOTIF_W, default 88, notification width; length field is bits [31:16].
REQ-003 SHALL have parameters: MIN_LEN, default 64, and MAX_LEN, default 4096, the accepted byte-length bounds (inclusive).
REQ-004 SHALL have parameter: ADDR_BITS, default 12, log2 depth of each internal FIFO.
REQ-005 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_notifications_TDATA/TVALID/TREADY  in/in/out  NOTIF_W/1/1  session notifications.
- s_axis_rx_data_TDATA/TVALID/TREADY  in/in/out  DATA_W+1/1/1  payload; MSB is tlast.
- m_axis_read_package_TDATA/TVALID/TREADY  out/out/in  32/1/1  read request, equal to notification [31:0].
- pkt_tx_TDATA/TVALID/TREADY  out/out/in  NOTIF_W+DATA_W+1/1/1  {metadata, generated tlast, data}.
- err_len_mismatch  out  1  one-cycle pulse on framing error.
- drop_count  out  32  dropped notifications (PKT_RX_STATS_EN only).
- pkt_count  out  32  completed output packets (PKT_RX_STATS_EN only).

Function
REQ-006 SHALL buffer notifications, payload beats and accepted metadata in three separate FIFOs of depth 2^ADDR_BITS.
REQ-007 SHALL accept a notification when len >= MIN_LEN, len <= MAX_LEN and len mod (DATA_W/8) == 0. Every other notification is dropped, including len = 0 (connection close).
REQ-008 SHALL consume a dropped notification in the cycle it heads the FIFO. It issues no read request and pushes no metadata.
REQ-009 SHALL present an accepted notification on m_axis_read_package only when the metadata FIFO is not full. The read handshake and the metadata push SHALL occur in the same cycle; neither occurs alone.
REQ-010 SHALL accept every valid payload beat into the payload FIFO while it is not full. No edge detection is applied: every beat counts.
REQ-011 SHALL run an output FSM with states O_IDLE and O_STREAM.
- O_IDLE -> O_STREAM when the metadata FIFO is non-empty; beat counter loads len/(DATA_W/8).
- In O_STREAM, pkt_tx_TVALID = payload FIFO non-empty.
- Each pkt_tx handshake decrements the counter.
REQ-012 SHALL drive the pkt_tx tlast bit from the counter only: 1 when counter == 1, otherwise 0. The input tlast is never forwarded.
REQ-013 SHALL, on the handshake with counter == 1, pop the metadata FIFO and return to O_IDLE. If the metadata FIFO is still non-empty, it SHALL enter O_STREAM again in the next cycle.
REQ-014 SHALL pulse err_len_mismatch for one cycle on a handshake where the input tlast differs from the generated tlast. The data still passes and the framing follows the counter.
REQ-015 SHALL hold pkt_tx_TDATA stable while TVALID=1 and TREADY=0.
REQ-016 SHALL never drive pkt_tx_TVALID in O_IDLE.
REQ-017 SHALL deassert each TREADY when the corresponding FIFO is full. Back-pressure is the only flow control; no data is lost.

Reset
REQ-018 SHALL, on rst_n low, clear all FIFOs, the FSM (to O_IDLE), the beat counter and both counters, asynchronously.
REQ-019 SHALL hold all TVALID, TREADY and err_len_mismatch at 0 during reset.
REQ-020 SHALL discard any partially streamed packet when reset asserts mid-operation. After release, the first notification is processed as fresh.

Configuration
REQ-021 SHALL, when PKT_RX_STATS_EN is defined, increment drop_count per dropped notification and pkt_count per REQ-013 pop. Both are 32-bit wrapping counters: 0xFFFFFFFF+1 -> 0.
REQ-022 SHALL, when PKT_RX_STATS_EN is undefined, omit drop_count and pkt_count ports and logic entirely.

Verification
REQ-023 SHALL cover: notification len=128 with 2 beats, input tlast on beat 2 -> one read request 0x0080xxxx; 2 pkt_tx beats, tlast 0 then 1; metadata equal to notification.
REQ-024 SHALL cover: notifications len=0, 32, 100, 8192 -> no read requests; drop_count=4 (stats build).
REQ-025 SHALL cover: len=192 with input tlast on beat 2 of 3 -> err_len_mismatch pulses on beats 2 and 3; output tlast only on beat 3.
REQ-026 SHALL cover: pkt_tx_TREADY=0 for 20 cycles during a 64-beat (len=4096) packet -> data held stable; all 64 beats delivered in order; pkt_count=1.
REQ-027 SHALL cover: two back-to-back notifications (len=64, len=256) -> second packet's first beat carries second metadata; no idle gap required beyond one cycle.
REQ-028 SHALL cover: rst_n low during beat 3 of 4 -> outputs 0 within the same cycle; a new len=64 packet after release frames correctly.
